// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants, FSM state type and word-count helper for the OAM DMA controller.
package oam_dma_ctrl_pkg;

    localparam int unsigned DMA_DATA_W    = 32;
    localparam int unsigned DMA_ADDR_W    = 32;
    localparam int unsigned DMA_OAM_AW    = 8;
    localparam int unsigned MAX_SPR       = 64;
    localparam int unsigned WORDS_PER_SPR = 4;
    localparam int unsigned OAM_DEPTH     = MAX_SPR * WORDS_PER_SPR;
    localparam int unsigned SPR_IDX_W     = 6;
    localparam int unsigned SPR_CNT_W     = 7;
    localparam int unsigned WCNT_W        = $clog2(OAM_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_FINISH
    } dma_state_e;

    // Words to move for a sprite count; counts above MAX_SPR saturate.
    function automatic logic [WCNT_W-1:0] words_for(input logic [SPR_CNT_W-1:0] cnt);
        logic [SPR_CNT_W-1:0] sat;
        sat = (cnt > SPR_CNT_W'(MAX_SPR)) ? SPR_CNT_W'(MAX_SPR) : cnt;
        return WCNT_W'(sat) * WCNT_W'(WORDS_PER_SPR);
    endfunction

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU command, data-memory read port and OAM write port of the OAM DMA controller.
// master: the DMA controller. slave: CPU / memory / OAM / PPU environment.
interface oam_dma_ctrl_if
    import oam_dma_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DMA_DATA_W,
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned OAM_AW = DMA_OAM_AW
);
    logic                 start;
    logic [ADDR_W-1:0]    src_addr;
    logic [SPR_IDX_W-1:0] spr_first;
    logic [SPR_CNT_W-1:0] spr_count;
    logic                 ppu_oam_busy;
    logic                 mem_re;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 oam_we;
    logic [OAM_AW-1:0]    oam_addr;
    logic [DATA_W-1:0]    oam_wdata;
    logic                 cpu_stall;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, src_addr, spr_first, spr_count, ppu_oam_busy, mem_rdata,
        output mem_re, mem_addr, oam_we, oam_addr, oam_wdata, cpu_stall, busy, done
    );

    modport slave (
        output start, src_addr, spr_first, spr_count, ppu_oam_busy, mem_rdata,
        input  mem_re, mem_addr, oam_we, oam_addr, oam_wdata, cpu_stall, busy, done
    );

endinterface

// File: rtl/oam_dma_ctrl_addr_gen.sv
// Source byte address, OAM word address and remaining-word counters.
// Ports: clk, rst (sync, active-high), load (latch new transfer), step (one word written),
//        src_in/spr_first/spr_count (transfer arguments), src_addr/oam_addr (current
//        addresses), last_c (current word is the final one).
module oam_dma_ctrl_addr_gen
    import oam_dma_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned OAM_AW = DMA_OAM_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 step,
    input  logic [ADDR_W-1:0]    src_in,
    input  logic [SPR_IDX_W-1:0] spr_first,
    input  logic [SPR_CNT_W-1:0] spr_count,
    output logic [ADDR_W-1:0]    src_addr,
    output logic [OAM_AW-1:0]    oam_addr,
    output logic                 last_c
);

    logic [WCNT_W-1:0] words_left;

    // Both address counters wrap naturally at their widths.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_addr   <= '0;
            oam_addr   <= '0;
            words_left <= '0;
        end else if (load) begin
            src_addr   <= {src_in[ADDR_W-1:2], 2'b00};
            oam_addr   <= OAM_AW'({spr_first, 2'b00});
            words_left <= words_for(spr_count);
        end else if (step) begin
            src_addr   <= src_addr + ADDR_W'(4);
            oam_addr   <= oam_addr + OAM_AW'(1);
            words_left <= words_left - WCNT_W'(1);
        end
    end

    assign last_c = (words_left == WCNT_W'(1));

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: copies sprite attribute words from data memory into OAM,
// stalling the CPU for the duration and deferring OAM writes while the PPU scans OAM.
// Ports: clk, rst (sync, active-high), bus (oam_dma_ctrl_if.master: command, memory
//        read port, OAM write port, cpu_stall/busy/done status).
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DMA_DATA_W,
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned OAM_AW = DMA_OAM_AW
) (
    input  logic            clk,
    input  logic            rst,
    oam_dma_ctrl_if.master  bus
);

    dma_state_e        state;
    logic [DATA_W-1:0] hold;
    logic              hold_valid;
    logic              load;
    logic              step;
    logic              last_c;
    logic [ADDR_W-1:0] src_addr;
    logic [OAM_AW-1:0] oam_addr;

    assign load = (state == ST_IDLE) && bus.start && (bus.spr_count != '0);
    assign step = bus.oam_we;

    oam_dma_ctrl_addr_gen #(
        .ADDR_W (ADDR_W),
        .OAM_AW (OAM_AW)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .src_in    (bus.src_addr),
        .spr_first (bus.spr_first),
        .spr_count (bus.spr_count),
        .src_addr  (src_addr),
        .oam_addr  (oam_addr),
        .last_c    (last_c)
    );

    // Write strobe is decoded from the live PPU flag so it can never overlap a PPU scan.
    // On the first WRITE cycle the word comes straight from memory; afterwards from hold.
    assign bus.oam_we    = (state == ST_WRITE) && !bus.ppu_oam_busy;
    assign bus.oam_wdata = ((state == ST_WRITE) && !hold_valid) ? bus.mem_rdata : hold;
    assign bus.mem_addr  = src_addr;
    assign bus.oam_addr  = oam_addr;

    // Transfer sequencer with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            hold          <= '0;
            hold_valid    <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.cpu_stall <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        if (bus.spr_count != '0) begin
                            state         <= ST_FETCH;
                            bus.mem_re    <= 1'b1;
                            bus.busy      <= 1'b1;
                            bus.cpu_stall <= 1'b1;
                        end else begin
                            // Empty transfer: report completion without going busy.
                            state    <= ST_FINISH;
                            bus.done <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    state      <= ST_WRITE;
                    bus.mem_re <= 1'b0;
                end
                ST_WRITE: begin
                    if (!hold_valid) begin
                        hold       <= bus.mem_rdata;
                        hold_valid <= 1'b1;
                    end
                    if (!bus.ppu_oam_busy) begin
                        hold_valid <= 1'b0;
                        if (last_c) begin
                            state         <= ST_FINISH;
                            bus.done      <= 1'b1;
                            bus.busy      <= 1'b0;
                            bus.cpu_stall <= 1'b0;
                        end else begin
                            state      <= ST_FETCH;
                            bus.mem_re <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    state    <= ST_IDLE;
                    bus.done <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: expected memory reads and OAM writes are queued
// when a transfer is started and consumed as the DUT issues them.
module tb_oam_dma_ctrl;
    import oam_dma_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oam_dma_ctrl_if bus ();

    oam_dma_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int n_mem_re = 0;
    int n_oam_we = 0;

    logic [31:0] mem_q[$];
    logic [39:0] oam_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    // Data memory: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.mem_re) bus.mem_rdata <= mem_word(bus.mem_addr);
    end

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (bus.mem_re) begin
            n_mem_re++;
            if (mem_q.size() == 0) check("mem_re_unexpected", 1, 0);
            else                   check("mem_addr", bus.mem_addr, mem_q.pop_front());
        end
        if (bus.oam_we) begin
            n_oam_we++;
            check("oam_we_during_ppu", bus.ppu_oam_busy, 0);
            if (oam_q.size() == 0) check("oam_we_unexpected", 1, 0);
            else                   check("oam_write", {bus.oam_addr, bus.oam_wdata}, oam_q.pop_front());
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_re"},    bus.mem_re,    0);
        check({tag, "_oam_we"},    bus.oam_we,    0);
        check({tag, "_busy"},      bus.busy,      0);
        check({tag, "_cpu_stall"}, bus.cpu_stall, 0);
        check({tag, "_done"},      bus.done,      0);
        check({tag, "_mem_addr"},  bus.mem_addr,  0);
        check({tag, "_oam_addr"},  bus.oam_addr,  0);
        check({tag, "_oam_wdata"}, bus.oam_wdata, 0);
    endtask

    // Start a transfer, queue its expected traffic and track busy/done timing.
    task automatic run_xfer(input logic [31:0] src, input logic [5:0] first,
                            input logic [6:0] cnt, input int stall);
        int nspr, lat, n, busy_cycles;
        bit got;
        logic [31:0] base;
        nspr = (cnt > 7'd64) ? 64 : int'(cnt);
        lat  = 8 * nspr + 1 + stall;
        base = {src[31:2], 2'b00};
        for (int w = 0; w < nspr * 4; w++) begin
            mem_q.push_back(base + 32'(4 * w));
            oam_q.push_back({8'(int'(first) * 4 + w), mem_word(base + 32'(4 * w))});
        end
        bus.src_addr  = src;
        bus.spr_first = first;
        bus.spr_count = cnt;
        bus.start     = 1'b1;
        n = 0;
        got = 1'b0;
        busy_cycles = 0;
        while (!got && n < lat + 20) begin
            @(posedge clk);
            if (n == 0) #1 bus.start = 1'b0;
            n++;
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) busy_cycles++;
                check("busy", bus.busy, (nspr != 0) ? 1 : 0);
                check("cpu_stall", bus.cpu_stall, (nspr != 0) ? 1 : 0);
            end
        end
        check("done_seen", got, 1);
        check("done_latency", n, lat);
        check("busy_cycles", busy_cycles, (nspr != 0) ? lat - 1 : 0);
        check("busy_at_done", bus.busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("mem_q_drained", mem_q.size(), 0);
        check("oam_q_drained", oam_q.size(), 0);
    endtask

    initial begin
        int re0;
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.src_addr     = '0;
        bus.spr_first    = '0;
        bus.spr_count    = '0;
        bus.ppu_oam_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Single sprite from 0x100.
        run_xfer(32'h100, 6'd0, 7'd1, 0);

        // Empty transfer.
        run_xfer(32'h40, 6'd5, 7'd0, 0);

        // OAM wrap from sprite 63, unaligned source.
        run_xfer(32'h203, 6'd63, 7'd2, 0);

        // Source address wrap.
        run_xfer(32'hFFFF_FFF8, 6'd1, 7'd1, 0);

        // PPU holds off the second write for 5 cycles.
        re0 = n_mem_re;
        fork
            run_xfer(32'h300, 6'd10, 7'd1, 5);
            begin
                repeat (4) @(posedge clk);
                #1 bus.ppu_oam_busy = 1'b1;
                repeat (5) @(posedge clk);
                #1 bus.ppu_oam_busy = 1'b0;
            end
        join
        check("ppu_mem_re_count", n_mem_re - re0, 4);

        // Reset in the third cycle of a 4-sprite transfer.
        mem_q.push_back(32'h500);
        mem_q.push_back(32'h504);
        oam_q.push_back({8'd16, mem_word(32'h500)});
        bus.src_addr  = 32'h500;
        bus.spr_first = 6'd4;
        bus.spr_count = 7'd4;
        bus.start     = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_done", bus.done, 0);
            check("abort_no_busy", bus.busy, 0);
        end
        check("abort_mem_q", mem_q.size(), 0);
        check("abort_oam_q", oam_q.size(), 0);
        run_xfer(32'h600, 6'd8, 7'd1, 0);

        // Second start while busy is ignored.
        fork
            run_xfer(32'h400, 6'd2, 7'd2, 0);
            begin
                repeat (3) @(posedge clk);
                #2;
                bus.src_addr  = 32'h999;
                bus.spr_first = 6'd40;
                bus.spr_count = 7'd3;
                bus.start     = 1'b1;
                @(posedge clk);
                #2 bus.start = 1'b0;
            end
        join

        // Count above 64 saturates to 64 sprites.
        run_xfer(32'h1000, 6'd0, 7'd100, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sequences sprite-attribute transfers from data memory into OAM. The CPU issues one start command instead of a software loop of load-word / OAM-write pairs.
- Sits between the CPU memory stage, the data-memory read port and the OAM write port.
- Stalls the CPU while it owns the memory read port.
- Defers OAM writes while the PPU is scanning OAM.

Parameters:
- DATA_W, 32, data and memory word width.
- ADDR_W, 32, data-memory byte-address width.
- OAM_AW, 8, OAM word-address width (64 sprites x 4 words).
- MAX_SPR, 64, maximum sprites per transfer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle command strobe from the CPU control path.
- src_addr  in  ADDR_W  byte address of the first sprite word. Must be word aligned; bits [1:0] are ignored.
- spr_first  in  6  first destination sprite index.
- spr_count  in  7  sprites to copy, 0..64.
- ppu_oam_busy  in  1  PPU is reading OAM; DMA must not write.
- mem_re  out  1  data-memory read enable.
- mem_addr  out  ADDR_W  data-memory byte address.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_re.
- oam_we  out  1  OAM write enable.
- oam_addr  out  OAM_AW  OAM word address.
- oam_wdata  out  DATA_W  OAM write data.
- cpu_stall  out  1  freeze the CPU pipeline.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: single clock domain on clk; rst is synchronous and active-high.
- Reset state: FSM = IDLE. mem_re, oam_we, cpu_stall, busy and done are 0. mem_addr, oam_addr and oam_wdata are 0.
- States: IDLE, FETCH, WRITE, FINISH.

- IDLE:
  - start=1 and spr_count!=0: latch src_addr with bits [1:0] forced to 0, oam_addr = {spr_first,2'b00}, word counter = spr_count*4. Go to FETCH. busy=1 and cpu_stall=1 from the next cycle.
  - start=1 and spr_count=0: no transfer; done=1 on the next cycle; busy stays 0.
  - start while busy is ignored.

- FETCH (1 cycle):
  - mem_re=1, mem_addr = current source address.
  - Go to WRITE.

- WRITE:
  - Capture mem_rdata into the hold register on the first WRITE cycle only.
  - ppu_oam_busy=0: oam_we=1, oam_wdata = held word. Then source += 4, oam_addr += 1 (wraps modulo 2^OAM_AW), counter -= 1.
    - counter reaches 0: go to FINISH.
    - otherwise: go to FETCH.
  - ppu_oam_busy=1: oam_we=0; stay in WRITE holding the data. Memory is not re-read.

- FINISH (1 cycle):
  - done=1, busy=0, cpu_stall=0.
  - Return to IDLE.

- Timing:
  - Unblocked throughput is 1 word per 2 cycles.
  - N sprites with no PPU contention: busy for 8N cycles; done pulses 8N+1 cycles after the start cycle.
- cpu_stall equals busy. The CPU does not need the memory port during a transfer.
- OAM wrap: a transfer starting at sprite 63 with count 2 writes words 252..255, then 0..3. There is no error.
- Source address is unbounded; it wraps modulo 2^ADDR_W.
- spr_count > 64 saturates to 64.
- rst mid-transfer: abort immediately. All outputs go to their reset values; no done pulse.
- oam_we is never asserted in the same cycle as ppu_oam_busy=1.

Decomposition:
- Shared package: FSM state enum, WORDS_PER_SPR=4, OAM_DEPTH.
- Natural sub-module: oam_dma_addr_gen, holding the source and OAM address counters and the word counter with load/increment.
- FSM and hold register stay in the top module.

Test Plan:
1. start, src_addr=0x100, spr_first=0, spr_count=1, mem returns 0xA0..0xA3:
   - OAM words 0..3 = A0..A3.
   - mem_addr sequence 0x100, 0x104, 0x108, 0x10C.
   - done pulses at cycle 9; busy high for 8 cycles.
2. spr_count=0:
   - done next cycle.
   - No mem_re, oam_we or cpu_stall.
3. spr_first=63, spr_count=2:
   - oam_addr sequence 252, 253, 254, 255, 0, 1, 2, 3.
4. ppu_oam_busy held high for 5 cycles during the 2nd WRITE:
   - No oam_we during those cycles.
   - Written data unchanged; mem_re count still 4.
   - done delayed by 5 cycles.
5. rst asserted in the 3rd cycle of a 4-sprite transfer:
   - Next cycle all outputs are 0.
   - No done pulse.
   - A new start then completes normally.
6. start pulsed again while busy, with different args:
   - Ignored; the original transfer completes with the original addresses.
